// File: rtl/fpu_align_stage.sv
// Two-stage FP add/sub alignment: S1 picks the large operand and the shift amount,
// S2 right-shifts the small significand and collects guard/round/sticky bits.
module fpu_align_stage #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_sign_a,
    input  logic               i_sign_b,
    input  logic [EXP_W-1:0]   i_exp_a,
    input  logic [EXP_W-1:0]   i_exp_b,
    input  logic [MAN_W-1:0]   i_man_a,
    input  logic [MAN_W-1:0]   i_man_b,
    input  logic [EXP_W-1:0]   i_exp_diff,
    input  logic               i_borrow,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_sign_large,
    output logic               o_sign_small,
    output logic [EXP_W-1:0]   o_exp_large,
    output logic [MAN_W+3:0]   o_man_large,
    output logic [MAN_W+3:0]   o_man_small,
    output logic               o_swap
);

    localparam int FW    = MAN_W + 4;
    localparam int SIG_W = MAN_W + 1;
    localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(FW);

    // Right shift with sticky: bit 0 of the result absorbs everything shifted past it.
    function automatic logic [FW-1:0] align_small(input logic [SIG_W-1:0] sig,
                                                  input logic [EXP_W-1:0] shift);
        logic [FW-1:0] ext;
        logic [FW-1:0] kept;
        logic [FW-1:0] lost_mask;
        logic          sticky;
        ext       = {sig, 3'b000};
        kept      = ext >> shift;
        lost_mask = ~({FW{1'b1}} << shift);
        sticky    = |(ext & lost_mask);
        return {kept[FW-1:1], kept[0] | sticky};
    endfunction

    logic               s1_valid_r;
    logic               s1_swap_r;
    logic               s1_sign_large_r;
    logic               s1_sign_small_r;
    logic [EXP_W-1:0]   s1_exp_large_r;
    logic [SIG_W-1:0]   s1_sig_large_r;
    logic [SIG_W-1:0]   s1_sig_small_r;
    logic [EXP_W-1:0]   s1_shift_r;

    logic               s2_ready_s;
    logic               sign_large_s;
    logic               sign_small_s;
    logic [EXP_W-1:0]   exp_large_s;
    logic [SIG_W-1:0]   sig_large_s;
    logic [SIG_W-1:0]   sig_small_s;
    logic [EXP_W-1:0]   mag_s;
    logic [EXP_W-1:0]   shift_s;

    assign s2_ready_s = ~o_valid | i_ready;
    assign o_ready    = ~s1_valid_r | s2_ready_s;

    // S1 operand swap, hidden-bit insertion and saturated shift magnitude.
    always_comb begin
        sign_large_s = i_sign_a;
        sign_small_s = i_sign_b;
        exp_large_s  = i_exp_a;
        sig_large_s  = {|i_exp_a, i_man_a};
        sig_small_s  = {|i_exp_b, i_man_b};
        mag_s        = i_exp_diff;
        shift_s      = {EXP_W{1'b0}};
        if (i_borrow) begin
            sign_large_s = i_sign_b;
            sign_small_s = i_sign_a;
            exp_large_s  = i_exp_b;
            sig_large_s  = {|i_exp_b, i_man_b};
            sig_small_s  = {|i_exp_a, i_man_a};
            mag_s        = ~i_exp_diff + EXP_W'(1);
        end else begin
            mag_s        = i_exp_diff;
        end
        if (mag_s >= SHIFT_SAT) begin
            shift_s = SHIFT_SAT;
        end else begin
            shift_s = mag_s;
        end
    end

    // S1 register: loads on input transfer, holds while S2 is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r      <= 1'b0;
            s1_swap_r       <= 1'b0;
            s1_sign_large_r <= 1'b0;
            s1_sign_small_r <= 1'b0;
            s1_exp_large_r  <= {EXP_W{1'b0}};
            s1_sig_large_r  <= {SIG_W{1'b0}};
            s1_sig_small_r  <= {SIG_W{1'b0}};
            s1_shift_r      <= {EXP_W{1'b0}};
        end else if (o_ready) begin
            s1_valid_r <= i_valid;
            if (i_valid) begin
                s1_swap_r       <= i_borrow;
                s1_sign_large_r <= sign_large_s;
                s1_sign_small_r <= sign_small_s;
                s1_exp_large_r  <= exp_large_s;
                s1_sig_large_r  <= sig_large_s;
                s1_sig_small_r  <= sig_small_s;
                s1_shift_r      <= shift_s;
            end
        end
    end

    // S2 register: aligned outputs, loaded when the output slot is free or draining.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_swap       <= 1'b0;
            o_sign_large <= 1'b0;
            o_sign_small <= 1'b0;
            o_exp_large  <= {EXP_W{1'b0}};
            o_man_large  <= {FW{1'b0}};
            o_man_small  <= {FW{1'b0}};
        end else if (s2_ready_s) begin
            o_valid <= s1_valid_r;
            if (s1_valid_r) begin
                o_swap       <= s1_swap_r;
                o_sign_large <= s1_sign_large_r;
                o_sign_small <= s1_sign_small_r;
                o_exp_large  <= s1_exp_large_r;
                o_man_large  <= {s1_sig_large_r, 3'b000};
                o_man_small  <= align_small(s1_sig_small_r, s1_shift_r);
            end
        end
    end

endmodule
